mips_multicycle_core: RTL and testbench

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_defs.sv | 42 ++++
 rtl/mips_regfile.sv | 32 +++
 rtl/mips_multicycle_core.sv | 206 ++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared opcode/funct constants, FSM state encoding and decode bundle for the
// multicycle MIPS core.
package mips_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic               legal;
    logic               reg_we;
    logic [RADDR_W-1:0] dst;
    logic               is_load;
    logic               is_store;
  } dec_t;

endpackage

// File: rtl/mips_regfile.sv
// Register file: two combinational read ports, one synchronous write port;
// register 0 reads as zero and ignores writes.
module mips_regfile
  import mips_defs::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RADDR_W-1:0] ra1,
  input  logic [RADDR_W-1:0] ra2,
  input  logic [RADDR_W-1:0] wa,
  input  logic               we,
  input  logic [XLEN-1:0]    wd,
  output logic [XLEN-1:0]    rd1_c,
  output logic [XLEN-1:0]    rd2_c
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1_c = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2_c = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: IF/ID/EX/MEM/WB FSM with decode, ALU and
// registered memory-interface outputs.
module mips_multicycle_core
  import mips_defs::*;
#(
  parameter int unsigned DADDR_W  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        IR_addr,
  input  logic [31:0]        IR,
  input  logic               IR_valid,
  input  logic [31:0]        ReadDataMem,
  input  logic               mem_ready,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DADDR_W-1:0] A,
  output logic [31:0]        Data2Mem,
  output logic               retire,
  output logic               illegal
);

  state_t state, state_nx;
  logic [XLEN-1:0] pc, ir, opa, opb, imm_ext, alu_out, npc, mdr;
  logic [XLEN-1:0] rd1_c, rd2_c, alu_c, npc_c, pc4_c, wdata_c;
  dec_t dec_c;

  logic               cen_nx, wen_nx, oen_nx, retire_nx, illegal_nx;
  logic [DADDR_W-1:0] a_nx;
  logic [XLEN-1:0]    d2m_nx;

  logic [5:0]         op, funct;
  logic [RADDR_W-1:0] rs, rt, rd, shamt;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign pc4_c   = pc + 32'd4;
  assign wdata_c = dec_c.is_load ? mdr : alu_out;
  assign IR_addr = pc;

  mips_regfile #(.NREGS(NREGS)) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (rs),
    .ra2  (rt),
    .wa   (dec_c.dst),
    .we   ((state == S_WB) && dec_c.reg_we),
    .wd   (wdata_c),
    .rd1_c(rd1_c),
    .rd2_c(rd2_c)
  );

  // Decode, ALU and next-PC; operands are the registers captured in ID.
  always_comb begin
    dec_c       = '0;
    dec_c.legal = 1'b1;
    dec_c.dst   = rd;
    alu_c       = '0;
    npc_c       = pc4_c;
    case (op)
      OP_RTYPE: begin
        dec_c.reg_we = 1'b1;
        case (funct)
          FN_ADD: alu_c = opa + opb;
          FN_SUB: alu_c = opa - opb;
          FN_AND: alu_c = opa & opb;
          FN_OR:  alu_c = opa | opb;
          FN_SLT: alu_c = {31'd0, $signed(opa) < $signed(opb)};
          FN_SLL: alu_c = opb << shamt;
          FN_SRL: alu_c = opb >> shamt;
          FN_JR: begin
            dec_c.reg_we = 1'b0;
            npc_c        = opa;
          end
          default: begin
            dec_c.reg_we = 1'b0;
            dec_c.legal  = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_c.reg_we = 1'b1;
        dec_c.dst    = rt;
        alu_c        = opa + imm_ext;
      end
      OP_LW: begin
        dec_c.reg_we  = 1'b1;
        dec_c.dst     = rt;
        dec_c.is_load = 1'b1;
        alu_c         = opa + imm_ext;
      end
      OP_SW: begin
        dec_c.is_store = 1'b1;
        alu_c          = opa + imm_ext;
      end
      OP_BEQ: if (opa == opb) npc_c = pc4_c + (imm_ext << 2);
      OP_BNE: if (opa != opb) npc_c = pc4_c + (imm_ext << 2);
      OP_J:   npc_c = {pc4_c[31:28], ir[25:0], 2'b00};
      OP_JAL: begin
        dec_c.reg_we = 1'b1;
        dec_c.dst    = 5'd31;
        alu_c        = pc4_c;
        npc_c        = {pc4_c[31:28], ir[25:0], 2'b00};
      end
      default: dec_c.legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IF;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IF:    if (IR_valid) state_nx = S_ID;
      S_ID:    state_nx = S_EX;
      S_EX:    state_nx = (dec_c.is_load || dec_c.is_store) ? S_MEM : S_WB;
      S_MEM:   if (mem_ready) state_nx = S_WB;
      S_WB:    state_nx = S_IF;
      default: state_nx = S_IF;
    endcase
  end

  // Next values of the registered outputs; memory address/data latch on EX->MEM.
  always_comb begin
    cen_nx     = 1'b1;
    wen_nx     = 1'b1;
    oen_nx     = 1'b1;
    a_nx       = A;
    d2m_nx     = Data2Mem;
    retire_nx  = 1'b0;
    illegal_nx = 1'b0;
    if (state_nx == S_MEM) begin
      cen_nx = 1'b0;
      wen_nx = !dec_c.is_store;
      oen_nx = !dec_c.is_load;
    end
    if ((state == S_EX) && (state_nx == S_MEM)) begin
      a_nx = alu_c[DADDR_W-1:0];
      if (dec_c.is_store) d2m_nx = opb;
    end
    if (state_nx == S_WB) begin
      retire_nx  = 1'b1;
      illegal_nx = !dec_c.legal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
      A        <= '0;
      Data2Mem <= '0;
      retire   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      CEN      <= cen_nx;
      WEN      <= wen_nx;
      OEN      <= oen_nx;
      A        <= a_nx;
      Data2Mem <= d2m_nx;
      retire   <= retire_nx;
      illegal  <= illegal_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      opa     <= '0;
      opb     <= '0;
      imm_ext <= '0;
      alu_out <= '0;
      npc     <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        S_IF: if (IR_valid) ir <= IR;
        S_ID: begin
          opa     <= rd1_c;
          opb     <= rd2_c;
          imm_ext <= {{16{ir[15]}}, ir[15:0]};
        end
        S_EX: begin
          alu_out <= alu_c;
          npc     <= npc_c;
        end
        S_MEM: if (mem_ready) mdr <= ReadDataMem;
        S_WB:  pc <= npc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core; register contents are observed by
// storing them and checking Data2Mem.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] IR_addr, IR, ReadDataMem, Data2Mem;
  logic        IR_valid, mem_ready, CEN, WEN, OEN, retire, illegal;
  logic [6:0]  A;

  int          vecs = 0;
  int          errs = 0;
  logic [31:0] pc_m;

  int          r_lat, r_cen;
  logic [6:0]  r_a;
  logic        r_wen, r_oen, r_stable, r_ill, r_ret_after, r_to;
  logic [31:0] r_d2m, r_next;

  always #5 clk = ~clk;

  mips_multicycle_core #(.DADDR_W(7), .RESET_PC(32'h0000_0000), .NREGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .IR_addr    (IR_addr),
    .IR         (IR),
    .IR_valid   (IR_valid),
    .ReadDataMem(ReadDataMem),
    .mem_ready  (mem_ready),
    .CEN        (CEN),
    .WEN        (WEN),
    .OEN        (OEN),
    .A          (A),
    .Data2Mem   (Data2Mem),
    .retire     (retire),
    .illegal    (illegal)
  );

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  // Runs one instruction from IF through WB plus one cycle; leaves the core in IF.
  task automatic exec(input logic [31:0] instr, input int ir_wait, input int mem_wait);
    int edges;
    edges = 0;
    r_lat = 0; r_cen = 0; r_stable = 1'b1; r_ill = 1'b0; r_to = 1'b1;
    r_a = '0; r_wen = 1'b1; r_oen = 1'b1; r_d2m = '0;
    IR = instr; IR_valid = (ir_wait == 0); mem_ready = 1'b1; ReadDataMem = 32'h1234_5678;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges >= ir_wait) IR_valid = 1'b1;
      if (edges > ir_wait) IR = 32'hFFFF_FFFF;
      if (!CEN) begin
        r_cen++;
        if (r_cen == 1) begin
          r_a = A; r_wen = WEN; r_oen = OEN; r_d2m = Data2Mem;
        end else if (A !== r_a || WEN !== r_wen || OEN !== r_oen || Data2Mem !== r_d2m) begin
          r_stable = 1'b0;
        end
        mem_ready   = (r_cen > mem_wait);
        ReadDataMem = mem_ready ? 32'hDEAD_BEEF : 32'h1234_5678;
      end else begin
        mem_ready   = 1'b1;
        ReadDataMem = 32'h1234_5678;
      end
      if (retire) begin
        r_to  = 1'b0;
        r_lat = edges + 1;
        r_ill = illegal;
        break;
      end
    end
    @(posedge clk); #1;
    r_ret_after = retire;
    r_next      = IR_addr;
    IR_valid    = 1'b0;
    mem_ready   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; IR_valid = 1'b0; mem_ready = 1'b0; IR = '0; ReadDataMem = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (IR_addr !== 32'h0) begin errs++; $display("FAIL reset_pc: got %h expected %h", IR_addr, 32'h0); end
    vecs++; if ({CEN, WEN, OEN} !== 3'b111) begin errs++; $display("FAIL reset_enables: got %b expected 111", {CEN, WEN, OEN}); end
    vecs++; if (A !== 7'd0 || Data2Mem !== 32'h0) begin errs++; $display("FAIL reset_bus: got A=%h D=%h expected 0/0", A, Data2Mem); end
    vecs++; if ({retire, illegal} !== 2'b00) begin errs++; $display("FAIL reset_pulses: got %b expected 00", {retire, illegal}); end
    rst_n = 1'b1;
    pc_m  = 32'h0;
  endtask

  task automatic test_addi();
    exec(itype(6'h08, 5'd0, 5'd1, 16'd5), 0, 0);
    vecs++; if (r_to || r_lat !== 4) begin errs++; $display("FAIL addi_latency: got %0d expected 4 (timeout=%b)", r_lat, r_to); end
    vecs++; if (r_ill !== 1'b0) begin errs++; $display("FAIL addi_illegal: got %b expected 0", r_ill); end
    vecs++; if (r_ret_after !== 1'b0) begin errs++; $display("FAIL retire_one_cycle: got %b expected 0", r_ret_after); end
    vecs++; if (r_next !== 32'd4) begin errs++; $display("FAIL addi_next_pc: got %h expected %h", r_next, 32'd4); end
    pc_m = 32'd4;
  endtask

  task automatic test_store();
    exec(itype(6'h2B, 5'd0, 5'd1, 16'd8), 0, 3);
    vecs++; if (r_cen !== 4 || r_stable !== 1'b1) begin errs++; $display("FAIL sw_hold: got %0d cycles stable=%b expected 4 stable=1", r_cen, r_stable); end
    vecs++; if ({r_wen, r_oen} !== 2'b01) begin errs++; $display("FAIL sw_enables: got %b expected 01", {r_wen, r_oen}); end
    vecs++; if (r_a !== 7'd8 || r_d2m !== 32'd5) begin errs++; $display("FAIL sw_bus: got A=%0d D=%h expected 8/5", r_a, r_d2m); end
    vecs++; if (r_to || r_lat !== 8) begin errs++; $display("FAIL sw_latency: got %0d expected 8", r_lat); end
    vecs++; if (r_next !== 32'd8) begin errs++; $display("FAIL sw_next_pc: got %h expected %h", r_next, 32'd8); end
    pc_m = 32'd8;
  endtask

  task automatic test_load();
    exec(itype(6'h23, 5'd0, 5'd2, 16'd8), 0, 0);
    vecs++; if ({r_wen, r_oen} !== 2'b10 || r_a !== 7'd8) begin errs++; $display("FAIL lw_bus: got WEN/OEN=%b A=%0d expected 10/8", {r_wen, r_oen}, r_a); end
    vecs++; if (r_to || r_lat !== 5) begin errs++; $display("FAIL lw_latency: got %0d expected 5", r_lat); end
    exec(itype(6'h2B, 5'd0, 5'd2, 16'd0), 0, 0);
    vecs++; if (r_d2m !== 32'hDEAD_BEEF) begin errs++; $display("FAIL lw_data: got %h expected DEADBEEF", r_d2m); end
    vecs++; if (r_next !== 32'd16) begin errs++; $display("FAIL lw_next_pc: got %h expected %h", r_next, 32'd16); end
    pc_m = 32'd16;
  endtask

  task automatic test_branch();
    exec(itype(6'h05, 5'd1, 5'd0, 16'hFFFE), 0, 0);
    vecs++; if (r_to || r_next !== 32'd12) begin errs++; $display("FAIL bne_taken: got %h expected %h", r_next, 32'd12); end
    exec(itype(6'h08, 5'd0, 5'd3, 16'hFFFF), 2, 0);
    vecs++; if (r_to || r_lat !== 6) begin errs++; $display("FAIL ir_wait_latency: got %0d expected 6", r_lat); end
    exec(itype(6'h04, 5'd1, 5'd0, 16'hFFFE), 0, 0);
    vecs++; if (r_to || r_next !== 32'd20) begin errs++; $display("FAIL beq_not_taken: got %h expected %h", r_next, 32'd20); end
    pc_m = 32'd20;
  endtask

  task automatic test_jump();
    exec({6'h03, 26'h40}, 0, 0);
    vecs++; if (r_to || r_next !== 32'h100) begin errs++; $display("FAIL jal_target: got %h expected %h", r_next, 32'h100); end
    exec(rtype(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 0, 0);
    vecs++; if (r_to || r_next !== 32'd24) begin errs++; $display("FAIL jr_link: got %h expected %h", r_next, 32'd24); end
    pc_m = 32'd24;
  endtask

  // $1=5, $3=-1; each result is stored and compared on Data2Mem.
  task automatic test_alu();
    logic [31:0] code [9];
    logic [4:0]  dst  [9];
    logic [31:0] expv [9];
    code = '{rtype(5'd1, 5'd3, 5'd4, 5'd0, 6'h20), rtype(5'd1, 5'd3, 5'd5, 5'd0, 6'h22),
             rtype(5'd1, 5'd5, 5'd6, 5'd0, 6'h24), rtype(5'd1, 5'd5, 5'd7, 5'd0, 6'h25),
             rtype(5'd3, 5'd1, 5'd8, 5'd0, 6'h2A), rtype(5'd1, 5'd3, 5'd9, 5'd0, 6'h2A),
             rtype(5'd0, 5'd1, 5'd10, 5'd4, 6'h00), rtype(5'd0, 5'd3, 5'd11, 5'd28, 6'h02),
             rtype(5'd3, 5'd3, 5'd12, 5'd0, 6'h20)};
    dst  = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    expv = '{32'd4, 32'd6, 32'd4, 32'd7, 32'd1, 32'd0, 32'h50, 32'hF, 32'hFFFF_FFFE};
    for (int i = 0; i < 9; i++) begin
      exec(code[i], 0, 0);
      exec(itype(6'h2B, 5'd0, dst[i], 16'd0), 0, 0);
      pc_m = pc_m + 32'd8;
      vecs++;
      if (r_to || r_d2m !== expv[i] || r_next !== pc_m)
        begin errs++; $display("FAIL alu_%0d: got %h pc %h expected %h pc %h", i, r_d2m, r_next, expv[i], pc_m); end
    end
  endtask

  task automatic test_illegal();
    exec(32'hFC22_0007, 0, 0);
    vecs++; if (r_to || r_ill !== 1'b1 || r_cen !== 0) begin errs++; $display("FAIL illegal_op: got ill=%b mem=%0d expected 1/0", r_ill, r_cen); end
    vecs++; if (r_next !== pc_m + 32'd4) begin errs++; $display("FAIL illegal_op_pc: got %h expected %h", r_next, pc_m + 32'd4); end
    exec(rtype(5'd2, 5'd2, 5'd1, 5'd0, 6'h3F), 0, 0);
    vecs++; if (r_to || r_ill !== 1'b1) begin errs++; $display("FAIL illegal_funct: got %b expected 1", r_ill); end
    exec(itype(6'h2B, 5'd0, 5'd1, 16'd0), 0, 0);
    vecs++; if (r_d2m !== 32'd5) begin errs++; $display("FAIL illegal_no_wr1: got %h expected 5", r_d2m); end
    exec(itype(6'h2B, 5'd0, 5'd2, 16'd0), 0, 0);
    vecs++; if (r_d2m !== 32'hDEAD_BEEF) begin errs++; $display("FAIL illegal_no_wr2: got %h expected DEADBEEF", r_d2m); end
    pc_m = pc_m + 32'd16;
  endtask

  task automatic test_wrap_zero();
    exec(itype(6'h08, 5'd0, 5'd13, 16'hFFFC), 0, 0);
    exec(rtype(5'd13, 5'd0, 5'd0, 5'd0, 6'h08), 0, 0);
    vecs++; if (r_to || r_next !== 32'hFFFF_FFFC) begin errs++; $display("FAIL jr_top: got %h expected FFFFFFFC", r_next); end
    exec(itype(6'h08, 5'd0, 5'd0, 16'd7), 0, 0);
    vecs++; if (r_to || r_next !== 32'h0) begin errs++; $display("FAIL pc_wrap: got %h expected 0", r_next); end
    exec(itype(6'h2B, 5'd0, 5'd0, 16'd0), 0, 0);
    vecs++; if (r_d2m !== 32'h0) begin errs++; $display("FAIL r0_write: got %h expected 0", r_d2m); end
  endtask

  task automatic test_reset_mem();
    IR = itype(6'h2B, 5'd0, 5'd1, 16'd8); IR_valid = 1'b1; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (CEN !== 1'b0) begin errs++; $display("FAIL mem_entry: got CEN=%b expected 0", CEN); end
    rst_n = 1'b0; IR_valid = 1'b0;
    @(posedge clk); #1;
    vecs++; if ({CEN, WEN, OEN, retire} !== 4'b1110) begin errs++; $display("FAIL reset_in_mem: got %b expected 1110", {CEN, WEN, OEN, retire}); end
    vecs++; if (IR_addr !== 32'h0) begin errs++; $display("FAIL reset_in_mem_pc: got %h expected 0", IR_addr); end
    rst_n = 1'b1;
    exec(itype(6'h2B, 5'd0, 5'd1, 16'd0), 0, 0);
    vecs++; if (r_to || r_d2m !== 32'h0 || r_next !== 32'd4) begin errs++; $display("FAIL regs_cleared: got %h pc %h expected 0 pc 4", r_d2m, r_next); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store();
    test_load();
    test_branch();
    test_jump();
    test_alu();
    test_illegal();
    test_wrap_zero();
    test_reset_mem();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
